decay_interval_timer: RTL and testbench
=======================================

# decay_interval_timer

Measures the interval between a muon-arrival pulse (`start_in`) and a decay-electron pulse (`stop_in`) in clock cycles. It sits downstream of the scintillator discriminators and ahead of the histogram/readout logic. It is the count-up, measuring counterpart of the fixed-length countdown timer. Each accepted interval is presented as one word on a valid/ready output. Windows that time out and results that get dropped are counted.

## Interface
- `WINDOW_CYCLES`, default 2000: coincidence window, 20 µs at 100 MHz. Must be at least `MIN_CYCLES` and must fit in `CNT_W`.
- `MIN_CYCLES`, default 2: stops seen before this count are ignored (ringing rejection).
- `DEAD_CYCLES`, default 100: holdoff after each measurement or timeout. Must be at least 1.
- `CNT_W`, default 32: width of the interval counter and `interval_data`.
- `clk`, input, 1: single clock. All logic is on the rising edge.
- `rst_n`, input, 1: reset, asynchronous and active-low.
- `start_in`, input, 1: asynchronous discriminator pulse, at least 2 `clk` periods wide.
- `stop_in`, input, 1: asynchronous discriminator pulse, at least 2 `clk` periods wide.
- `enable`, input, 1: arms the measurement. When low, no new starts are accepted and an interval in progress is aborted.
- `interval_data`, output, `CNT_W`: measured interval in cycles.
- `interval_valid`, output, 1: `interval_data` is available.
- `interval_ready`, input, 1: consumer accepts the current word.
- `timeout_count`, output, 16: number of windows that expired without a stop. Saturates.
- `lost_count`, output, 16: number of results dropped because the output was full. Saturates.
- `busy`, output, 1: high whenever the state is not IDLE.

## Operation
- Input conditioning:
  - Each of `start_in` and `stop_in` passes through a 2-FF synchronizer and then a rising-edge detector.
  - The detector produces a 1-cycle pulse, `start_p` or `stop_p`.
  - Both inputs have identical latency, so the measured interval is unaffected.
- States: IDLE, COUNT, DEAD.
- IDLE:
  - `enable && start_p` → COUNT and load `cnt` with 1.
  - `stop_p` alone is ignored.
- COUNT:
  - `cnt` increments by 1 each cycle. A stop pulse arriving N cycles after `start_p` therefore sees `cnt == N`.
  - `!enable` → IDLE. No output is produced and no counter changes. This has top priority.
  - Else, `stop_p && cnt >= MIN_CYCLES` → capture `cnt` and go to DEAD.
  - Else, `stop_p && cnt < MIN_CYCLES` → ignored; counting continues.
  - Else, `cnt == WINDOW_CYCLES` → `timeout_count` +1 (saturating) and go to DEAD.
  - A stop in the same cycle as `cnt == WINDOW_CYCLES` is a valid capture, not a timeout.
  - `start_p` in COUNT is ignored.
- DEAD:
  - Lasts exactly `DEAD_CYCLES` cycles, then → IDLE.
  - `start_p` and `stop_p` are ignored throughout.
- Capture:
  - The value is loaded into the output register if `!interval_valid`, or if `interval_valid && interval_ready` in the same cycle. In either case `interval_valid` is 1 the next cycle.
  - Otherwise the value is discarded, `lost_count` +1 (saturating), and the held word is unchanged.
- Output handshake:
  - `interval_data` is stable while `interval_valid` is high.
  - `interval_valid` falls the cycle after `valid && ready` unless a capture happens in that same cycle.
- Arithmetic:
  - `cnt` never exceeds `WINDOW_CYCLES`.
  - Status counters hold at 16'hFFFF.

## Timing
- Reset values: state IDLE; `cnt` 0; synchronizer and edge flops 0; `interval_data` 0; `interval_valid` 0; `timeout_count` 0; `lost_count` 0; `busy` 0.
- Reset mid-COUNT or mid-DEAD discards the interval in progress.
- Input latency: the pulse is asserted in cycle k+2, where the input is first sampled high at edge k.
- Capture latency: `interval_valid` rises 1 cycle after the `stop_p` cycle.
- `busy` rises 1 cycle after `start_p`. It falls `DEAD_CYCLES` cycles after the cycle that leaves COUNT.
- Dead time between events is `DEAD_CYCLES`+1 cycles after a capture or timeout, before a new start can be accepted.

## Structure
- Shared package `muon_pkg` holds:
  - the state enum `timer_state_t` (IDLE, COUNT, DEAD);
  - constant `STAT_W` = 16;
  - default cycle constants shared with the countdown timer.
- One sub-module, `pulse_sync`: 2-FF synchronizer plus rising-edge detector, with ports `clk`, `rst_n`, `d`, `pulse`. It is instantiated twice, once per input.

## Test plan
- Basic capture: `start_in`, then `stop_in` rising 500 cycles later, with `interval_ready`=1 → `interval_data`=500 and `interval_valid` high for 1 cycle; `busy` low 101 cycles after capture.
- Timeout: start with no stop → after 2000 counts `timeout_count` goes 0→1, `interval_valid` never rises, and the block returns to IDLE after DEAD.
- Window edge: stop at exactly 2000 → data 2000 and `timeout_count` unchanged. Stop at 2001 → timeout with no data.
- Backpressure: `interval_ready`=0 across two events of 300 and 700 cycles → data stays 300 and `lost_count`=1. Raising ready gives one handshake, then `interval_valid`=0.
- Rejection: stop 1 cycle after start is ignored, then stop at 10 → data 10. A start during DEAD is ignored. A start with `enable`=0 produces no `busy`.
- Reset and abort: `rst_n` low mid-COUNT → all outputs 0 and state IDLE. Dropping `enable` mid-COUNT → IDLE with no data and counters unchanged.

Source files
------------

// File: rtl/muon_pkg.sv
// Shared types and constants for the muon timing blocks.
// Holds the timer state enum, status counter width and default cycle counts.
package muon_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DEAD  = 2'd2
  } timer_state_t;

  localparam int STAT_W = 16;

  // 20 us window and 1 us holdoff at 100 MHz
  localparam int DEF_WINDOW_CYCLES = 2000;
  localparam int DEF_MIN_CYCLES    = 2;
  localparam int DEF_DEAD_CYCLES   = 100;

endpackage

// File: rtl/pulse_sync.sv
// 2-FF synchronizer followed by a rising-edge detector.
// Ports: clk, rst_n (async low), d (async level in), pulse (1-cycle out).
module pulse_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic pulse
);

  logic s1_q;
  logic s2_q;
  logic e_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      e_q  <= 1'b0;
    end else begin
      s1_q <= d;
      s2_q <= s1_q;
      e_q  <= s2_q;
    end
  end

  assign pulse = s2_q & ~e_q;

endmodule

// File: rtl/decay_interval_timer.sv
// Measures start->stop interval in cycles; one word per event on valid/ready.
// Ports: clk, rst_n, start_in, stop_in, enable, interval_*, counts, busy.
module decay_interval_timer
  import muon_pkg::*;
#(
  parameter int WINDOW_CYCLES = DEF_WINDOW_CYCLES,
  parameter int MIN_CYCLES    = DEF_MIN_CYCLES,
  parameter int DEAD_CYCLES   = DEF_DEAD_CYCLES,
  parameter int CNT_W         = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_in,
  input  logic              stop_in,
  input  logic              enable,
  output logic [CNT_W-1:0]  interval_data,
  output logic              interval_valid,
  input  logic              interval_ready,
  output logic [STAT_W-1:0] timeout_count,
  output logic [STAT_W-1:0] lost_count,
  output logic              busy
);

  localparam int DW = $clog2(DEAD_CYCLES + 1);

  typedef logic [CNT_W-1:0]  cnt_t;
  typedef logic [DW-1:0]     dead_t;
  typedef logic [STAT_W-1:0] stat_t;

  localparam cnt_t  WIN      = cnt_t'(WINDOW_CYCLES);
  localparam cnt_t  MIN      = cnt_t'(MIN_CYCLES);
  localparam dead_t DEAD_TOP = dead_t'(DEAD_CYCLES - 1);

  logic start_p;
  logic stop_p;

  pulse_sync u_start (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (start_in),
    .pulse (start_p)
  );

  pulse_sync u_stop (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (stop_in),
    .pulse (stop_p)
  );

  timer_state_t state_q, state_d;
  cnt_t         cnt_q, cnt_d;
  dead_t        dead_q, dead_d;
  cnt_t         data_q, data_d;
  logic         valid_q, valid_d;
  stat_t        tmo_q, tmo_d;
  stat_t        lost_q, lost_d;

  logic accept;
  logic capture;
  logic timeout;
  logic load;

  // A stop on the window's last count wins over the timeout
  always_comb begin
    accept  = (state_q == IDLE) && enable && start_p;
    capture = (state_q == COUNT) && enable
            && stop_p && (cnt_q >= MIN);
    timeout = (state_q == COUNT) && enable
            && !capture && (cnt_q == WIN);
    load    = capture && (!valid_q || interval_ready);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (accept) state_d = COUNT;
      end
      COUNT: begin
        if (!enable) state_d = IDLE;
        else if (capture || timeout) state_d = DEAD;
      end
      DEAD: begin
        if (dead_q == '0) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q != IDLE);
  end

  always_comb begin
    cnt_d  = cnt_q;
    dead_d = dead_q;
    data_d = data_q;
    valid_d = valid_q;
    tmo_d  = tmo_q;
    lost_d = lost_q;

    unique case (1'b1)
      accept: cnt_d = cnt_t'(1);
      state_q == COUNT: begin
        if (!enable || capture || timeout) begin
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + cnt_t'(1);
        end
      end
      default: cnt_d = cnt_q;
    endcase

    if (capture || timeout) begin
      dead_d = DEAD_TOP;
    end else if (state_q == DEAD && dead_q != '0) begin
      dead_d = dead_q - dead_t'(1);
    end

    if (timeout && tmo_q != '1) begin
      tmo_d = tmo_q + stat_t'(1);
    end

    if (load) begin
      data_d  = cnt_q;
      valid_d = 1'b1;
    end else if (valid_q && interval_ready) begin
      valid_d = 1'b0;
    end

    if (capture && !load && lost_q != '1) begin
      lost_d = lost_q + stat_t'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      dead_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      tmo_q   <= '0;
      lost_q  <= '0;
    end else begin
      cnt_q   <= cnt_d;
      dead_q  <= dead_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      tmo_q   <= tmo_d;
      lost_q  <= lost_d;
    end
  end

  assign interval_data  = data_q;
  assign interval_valid = valid_q;
  assign timeout_count  = tmo_q;
  assign lost_count     = lost_q;

endmodule

// File: tb/tb_decay_interval_timer.sv
// Directed bench for decay_interval_timer with an event-timestamp model.
// Checks every cycle against the model plus literal spot checks.
module tb_decay_interval_timer;

  localparam int W   = 2000;
  localparam int MN  = 2;
  localparam int D   = 100;
  localparam int CW  = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start_in;
  logic          stop_in;
  logic          enable;
  logic [CW-1:0] interval_data;
  logic          interval_valid;
  logic          interval_ready;
  logic [15:0]   timeout_count;
  logic [15:0]   lost_count;
  logic          busy;

  decay_interval_timer #(
    .WINDOW_CYCLES (W),
    .MIN_CYCLES    (MN),
    .DEAD_CYCLES   (D),
    .CNT_W         (CW)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start_in       (start_in),
    .stop_in        (stop_in),
    .enable         (enable),
    .interval_data  (interval_data),
    .interval_valid (interval_valid),
    .interval_ready (interval_ready),
    .timeout_count  (timeout_count),
    .lost_count     (lost_count),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string nm, input longint got,
                     input longint exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0d expected %0d",
               nm, $time, got, exp);
    end
  endtask

  // Model: phase 0 idle, 1 measuring, 2 holdoff; times are edge indices
  int     m_phase;
  longint m_cyc;
  longint m_t0;
  longint m_dead_end;
  bit     m_valid;
  longint m_data;
  int     m_tmo;
  int     m_lost;
  bit     sh[4];
  bit     ph[4];

  function automatic void model_reset();
    m_phase = 0;
    m_t0 = 0;
    m_dead_end = 0;
    m_valid = 0;
    m_data = 0;
    m_tmo = 0;
    m_lost = 0;
    for (int i = 0; i < 4; i++) begin
      sh[i] = 0;
      ph[i] = 0;
    end
  endfunction

  // Predicts the effect of the coming rising edge
  function automatic void model_step();
    bit     sp;
    bit     pp;
    bit     cap;
    longint capv;
    longint el;
    m_cyc++;
    for (int i = 3; i > 0; i--) begin
      sh[i] = sh[i-1];
      ph[i] = ph[i-1];
    end
    sh[0] = start_in;
    ph[0] = stop_in;
    // Input first sampled high at edge k acts at edge k+2
    sp = sh[2] && !sh[3];
    pp = ph[2] && !ph[3];
    cap = 0;
    capv = 0;
    if (m_phase == 0) begin
      if (enable && sp) begin
        m_phase = 1;
        m_t0 = m_cyc;
      end
    end else if (m_phase == 1) begin
      el = m_cyc - m_t0;
      if (!enable) begin
        m_phase = 0;
      end else if (pp && el >= MN) begin
        cap = 1;
        capv = el;
        m_phase = 2;
        m_dead_end = m_cyc + D;
      end else if (el == W) begin
        if (m_tmo < 65535) m_tmo++;
        m_phase = 2;
        m_dead_end = m_cyc + D;
      end
    end else begin
      if (m_cyc == m_dead_end) m_phase = 0;
    end
    if (cap) begin
      if (!m_valid || interval_ready) begin
        m_data = capv;
        m_valid = 1;
      end else if (m_lost < 65535) begin
        m_lost++;
      end
    end else if (m_valid && interval_ready) begin
      m_valid = 0;
    end
  endfunction

  initial begin
    m_cyc = 0;
    model_reset();
    forever begin
      @(negedge clk);
      if (!rst_n) model_reset();
      chk("valid", longint'(interval_valid), longint'(m_valid));
      if (m_valid) chk("data", longint'(interval_data), m_data);
      chk("busy", longint'(busy), longint'(m_phase != 0));
      chk("timeouts", longint'(timeout_count), longint'(m_tmo));
      chk("lost", longint'(lost_count), longint'(m_lost));
      if (rst_n) model_step();
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // Stop rises n cycles after start; returns just after the stop_p edge
  task automatic measure(input int n);
    start_in = 1'b1;
    tick(n);
    stop_in = 1'b1;
    tick(3);
    start_in = 1'b0;
    stop_in = 1'b0;
  endtask

  task automatic fire_start();
    start_in = 1'b1;
    tick(3);
    start_in = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    start_in = 1'b0;
    stop_in = 1'b0;
    enable = 1'b0;
    interval_ready = 1'b1;
    tick(3);
    chk("rst_valid", longint'(interval_valid), 0);
    chk("rst_data", longint'(interval_data), 0);
    chk("rst_busy", longint'(busy), 0);
    chk("rst_tmo", longint'(timeout_count), 0);
    chk("rst_lost", longint'(lost_count), 0);
    rst_n = 1'b1;
    tick(2);
    enable = 1'b1;

    measure(500);
    chk("basic_data", longint'(interval_data), 500);
    chk("basic_valid", longint'(interval_valid), 1);
    tick(1);
    chk("basic_valid_drop", longint'(interval_valid), 0);
    tick(98);
    chk("basic_busy_hold", longint'(busy), 1);
    tick(1);
    chk("basic_busy_fall", longint'(busy), 0);
    tick(20);

    fire_start();
    tick(1999);
    chk("tmo_before", longint'(timeout_count), 0);
    chk("tmo_busy", longint'(busy), 1);
    tick(1);
    chk("tmo_after", longint'(timeout_count), 1);
    chk("tmo_novalid", longint'(interval_valid), 0);
    tick(100);
    chk("tmo_idle", longint'(busy), 0);
    tick(10);

    measure(2000);
    chk("edge_data", longint'(interval_data), 2000);
    chk("edge_valid", longint'(interval_valid), 1);
    chk("edge_tmo", longint'(timeout_count), 1);
    tick(120);
    measure(2001);
    chk("over_valid", longint'(interval_valid), 0);
    chk("over_tmo", longint'(timeout_count), 2);
    tick(120);

    interval_ready = 1'b0;
    measure(300);
    chk("bp_first", longint'(interval_data), 300);
    tick(120);
    measure(700);
    chk("bp_hold", longint'(interval_data), 300);
    chk("bp_valid", longint'(interval_valid), 1);
    chk("bp_lost", longint'(lost_count), 1);
    tick(5);
    interval_ready = 1'b1;
    tick(1);
    chk("bp_drain", longint'(interval_valid), 0);
    tick(120);

    start_in = 1'b1;
    tick(1);
    stop_in = 1'b1;
    tick(3);
    stop_in = 1'b0;
    start_in = 1'b0;
    tick(6);
    stop_in = 1'b1;
    tick(3);
    stop_in = 1'b0;
    chk("rej_data", longint'(interval_data), 10);
    chk("rej_valid", longint'(interval_valid), 1);
    tick(10);
    fire_start();
    tick(97);
    chk("dead_start_busy", longint'(busy), 0);
    enable = 1'b0;
    fire_start();
    tick(3);
    chk("dis_busy", longint'(busy), 0);
    enable = 1'b1;
    tick(2);

    fire_start();
    tick(50);
    chk("mid_busy", longint'(busy), 1);
    rst_n = 1'b0;
    #1;
    chk("mr_valid", longint'(interval_valid), 0);
    chk("mr_data", longint'(interval_data), 0);
    chk("mr_busy", longint'(busy), 0);
    chk("mr_tmo", longint'(timeout_count), 0);
    chk("mr_lost", longint'(lost_count), 0);
    tick(2);
    rst_n = 1'b1;
    tick(3);

    fire_start();
    tick(50);
    enable = 1'b0;
    tick(1);
    chk("abort_busy", longint'(busy), 0);
    enable = 1'b1;
    stop_in = 1'b1;
    tick(3);
    stop_in = 1'b0;
    tick(2);
    chk("abort_valid", longint'(interval_valid), 0);
    chk("abort_tmo", longint'(timeout_count), 0);
    chk("abort_lost", longint'(lost_count), 0);
    tick(5);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
